hfrv_mem_wait_ctrl: RTL

- Memory-side responder on the HF-RISC CPU data bus. Consumes the CPU's address, data_write and data_we; produces data_read and stall.
- Drives a word-wide synchronous SRAM that has 1-cycle read latency.
- Inserts a programmable number of wait states before every in-range access.
- Flags out-of-range accesses and keeps a saturating count of stall cycles for performance regressions.

---
 rtl/hfrv_mem_wait_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/hfrv_mem_wait_ctrl.sv
// HF-RISC data-bus responder for a 1-cycle-latency word SRAM: programmable wait
// states before each in-range access, out-of-range error pulse, saturating stall counter.
`timescale 1ns/1ps
module hfrv_mem_wait_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
  parameter int unsigned ADDR_WIDTH  = 14,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           address,
  input  logic [31:0]           data_write,
  input  logic [3:0]            data_we,
  output logic [31:0]           data_read,
  output logic                  stall,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic                  err,
  output logic [31:0]           stall_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_GO} state_t;

  localparam logic [32:0] LP_WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] LP_WIN_HI = LP_WIN_LO + (33'd4 << ADDR_WIDTH);
  localparam bit          LP_NOWAIT = (WAIT_STATES == 0);
  localparam bit          LP_ONEWAIT = (WAIT_STATES == 1);
  // The IDLE cycle is itself the first stall cycle, so WAIT only covers WAIT_STATES-1.
  localparam logic [3:0]  LP_CNT_LOAD = (WAIT_STATES >= 2) ? 4'(WAIT_STATES - 2) : 4'd0;

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_cnt;
  logic [31:0]           r_req_addr;
  logic [31:0]           r_req_wdata;
  logic [3:0]            r_req_we;
  logic                  r_rd_valid;
  logic [31:0]           r_stall_count;
  logic                  r_protocol_err;
  logic                  w_in_range;

  assign w_in_range = ({1'b0, address} >= LP_WIN_LO) && ({1'b0, address} < LP_WIN_HI);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_req_addr     <= '0;
      r_req_wdata    <= '0;
      r_req_we       <= '0;
      r_rd_valid     <= 1'b0;
      r_stall_count  <= '0;
      r_protocol_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && stall) begin
        r_req_addr  <= address;
        r_req_wdata <= data_write;
        r_req_we    <= data_we;
        r_cnt       <= LP_CNT_LOAD;
      end else if (r_state == ST_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      r_rd_valid <= mem_en && (mem_we == '0);
      if (stall && r_stall_count != '1) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
      if (r_state == ST_WAIT && (address != r_req_addr || data_we != r_req_we)) begin
        r_protocol_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_in_range && !LP_NOWAIT) begin
          w_next = LP_ONEWAIT ? ST_GO : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_next = ST_GO;
        end
      end
      ST_GO:   w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    stall     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = address[ADDR_WIDTH+1:2];
    mem_wdata = data_write;
    err       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (reset) begin
          if (!w_in_range) begin
            err = 1'b1;
          end else if (LP_NOWAIT) begin
            mem_en = 1'b1;
            mem_we = data_we;
          end else begin
            stall = 1'b1;
          end
        end
      end
      ST_WAIT: stall = 1'b1;
      ST_GO: begin
        mem_en    = 1'b1;
        mem_we    = r_req_we;
        mem_addr  = r_req_addr[ADDR_WIDTH+1:2];
        mem_wdata = r_req_wdata;
      end
      default: ;
    endcase
  end

  assign data_read   = r_rd_valid ? mem_rdata : 32'h0;
  assign stall_count = r_stall_count;

  a_no_en_while_stall: assert property (@(posedge clk) disable iff (!reset) !(stall && mem_en));
  a_no_en_with_err:    assert property (@(posedge clk) disable iff (!reset) !(err && (mem_en || stall)));
  c_protocol_err:      cover property (@(posedge clk) r_protocol_err);

endmodule
